// File: rtl/shift_nbit_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROR) for the PIM ALU.
// One registered mux stage per shift-amount bit, each with valid/ready flow control.
module shift_nbit_pipe #(
  parameter int WIDTH       = 32,
  parameter int SHIFT_WIDTH = 5   // log2(WIDTH); also the number of stages
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SHIFT_WIDTH-1:0] in_shamt,
  input  logic [1:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [WIDTH-1:0]       d_q   [SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] s_q   [SHIFT_WIDTH];
  logic [1:0]             o_q   [SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] v_q;

  logic [WIDTH-1:0]       d_nxt [SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] s_nxt [SHIFT_WIDTH];
  logic [1:0]             o_nxt [SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] v_nxt;
  logic [SHIFT_WIDTH-1:0] adv;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam int AMT = 1 << k;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] sh;

    if (k == 0) begin : g_head
      assign d_in     = in_data;
      assign s_nxt[k] = in_shamt;
      assign o_nxt[k] = in_op;
      assign v_nxt[k] = in_valid;
    end else begin : g_link
      assign d_in     = d_q[k-1];
      assign s_nxt[k] = s_q[k-1];
      assign o_nxt[k] = o_q[k-1];
      assign v_nxt[k] = v_q[k-1];
    end

    // NOTE: sh gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
      sh = d_in;
      if (s_nxt[k][k]) begin
        case (o_nxt[k])
          OP_SLL:  sh = d_in << AMT;
          OP_SRL:  sh = d_in >> AMT;
          OP_SRA:  sh = $signed(d_in) >>> AMT;
          OP_ROR:  sh = (d_in >> AMT) | (d_in << (WIDTH - AMT));
          default: sh = d_in;
        endcase
      end
    end

    assign d_nxt[k] = sh;

    // Unrolled form of adv[k] = adv[k+1] || !v[k]: a stage advances unless it and
    // every stage downstream of it is occupied while the output is stalled.
    assign adv[k] = out_ready || !(&v_q[SHIFT_WIDTH-1:k]);
  end

  // NOTE: the payload registers are reset as well, so out_data reads 0 during reset
  // instead of stale or unknown data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < SHIFT_WIDTH; k++) begin
        d_q[k] <= '0;
        s_q[k] <= '0;
        o_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHIFT_WIDTH; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_nxt[k];
          if (v_nxt[k]) begin
            d_q[k] <= d_nxt[k];
            s_q[k] <= s_nxt[k];
            o_q[k] <= o_nxt[k];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[SHIFT_WIDTH-1];
  assign out_data  = d_q[SHIFT_WIDTH-1];

endmodule

// File: tb/tb_shift_nbit_pipe.sv
// Self-checking bench for shift_nbit_pipe: directed mode/extreme/backpressure/reset
// scenarios plus a randomized stream scored against a whole-shift reference model.
module tb_shift_nbit_pipe;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  shift_nbit_pipe #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  logic         last_acc;
  logic         last_drn;

  // Whole-operation reference: one shift by the full amount.
  function automatic logic [W-1:0] ref_shift(logic [W-1:0] a, int s, logic [1:0] op);
    case (op)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return W'($signed(a) >>> s);
      default: return (s == 0) ? a : ((a >> s) | (a << (W - s)));
    endcase
  endfunction

  task automatic present(logic [W-1:0] d, int s, logic [1:0] op, logic [W-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SW'(s);
    in_op    = op;
    cur_exp  = e;
  endtask

  // Called just after a falling edge: samples the handshakes that the next rising
  // edge will perform, scores any drained result, then moves to the next falling edge.
  task automatic step();
    #1;
    last_acc = in_valid && in_ready;
    last_drn = out_valid && out_ready;
    if (last_drn) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_data: unexpected result %h with nothing outstanding", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) $display("FAIL out_data: got %h expected %h", out_data, e);
        else n_pass++;
      end
    end
    if (last_acc) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic drain_wait(string name, int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s: %0d results outstanding, expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got v=%b d=%h r=%b expected v=0 d=0 r=1", out_valid, out_data, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'hA5A5_0000 + i, i + 1, 2'b01, 32'h0);
      step();
    end
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_midstream: got v=%b d=%h r=%b expected v=0 d=0 r=1", out_valid, out_data, in_ready);
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (out_valid) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) $display("FAIL reset_flush: got %0d valid cycles expected 0", seen);
    else n_pass++;
    present(32'h0000_00FF, 4, 2'b00, 32'h0000_0FF0);
    step();
    drain_wait("reset_new_input", 20);
  endtask

  task automatic test_modes();
    logic [W-1:0] want [4];
    int first_c, last_c, n_out;
    want[0] = 32'h0000_0F10;
    want[1] = 32'h0800_000F;
    want[2] = 32'hF800_000F;
    want[3] = 32'h1800_000F;
    out_ready = 1'b1;
    first_c = -1;
    last_c  = -1;
    n_out   = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 4) present(32'h8000_00F1, 4, 2'(c), want[c]);
      else in_valid = 1'b0;
      step();
      if (last_drn) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n_out++;
      end
    end
    n_checks++;
    if (first_c != 5) $display("FAIL mode_latency: first result at step %0d expected 5", first_c);
    else n_pass++;
    n_checks++;
    if (n_out != 4 || last_c != 8)
      $display("FAIL mode_back_to_back: got %0d results ending step %0d expected 4 ending 8", n_out, last_c);
    else n_pass++;
  endtask

  task automatic test_extremes();
    out_ready = 1'b1;
    present(32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF); step();
    present(32'h0000_0001, 31, 2'b00, 32'h8000_0000); step();
    present(32'h1234_5678,  0, 2'b11, 32'h1234_5678); step();
    present(32'h1234_5678,  8, 2'b11, 32'h7812_3456); step();
    present(32'hFFFF_FFFF,  0, 2'b01, 32'hFFFF_FFFF); step();
    drain_wait("extremes", 20);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d [8];
    int           s [8];
    logic [1:0]   o [8];
    int           sent, acc_before_stall;
    logic [W-1:0] held;
    int           moved;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom();
      s[i] = $urandom_range(SW'(W - 1));
      o[i] = 2'($urandom_range(3));
    end
    out_ready = 1'b0;
    sent = 0;
    present(d[0], s[0], o[0], ref_shift(d[0], s[0], o[0]));
    for (int c = 0; c < 12; c++) begin
      step();
      if (last_acc) begin
        sent++;
        present(d[sent], s[sent], o[sent], ref_shift(d[sent], s[sent], o[sent]));
      end
    end
    acc_before_stall = sent;
    n_checks++;
    if (acc_before_stall != 5) $display("FAIL bp_fill: got %0d accepts expected 5", acc_before_stall);
    else n_pass++;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_stall: got r=%b v=%b expected r=0 v=1", in_ready, out_valid);
    else n_pass++;
    held  = out_data;
    moved = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (out_data !== held || out_valid !== 1'b1) moved++;
    end
    n_checks++;
    if (moved != 0) $display("FAIL bp_hold: out_data changed in %0d cycles expected 0", moved);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    step();
    n_checks++;
    if (!(last_acc && last_drn))
      $display("FAIL bp_accept_drain: got acc=%b drn=%b expected 1 1", last_acc, last_drn);
    else n_pass++;
    sent++;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      present(d[sent], s[sent], o[sent], ref_shift(d[sent], s[sent], o[sent]));
      step();
      if (last_acc) sent++;
    end
    n_checks++;
    if (sent != 8) $display("FAIL bp_sent: got %0d expected 8", sent);
    else n_pass++;
    drain_wait("bp_drain", 30);
  endtask

  task automatic test_random();
    localparam int N = 10000;
    int sent, budget;
    sent     = 0;
    budget   = 0;
    in_valid = 1'b0;
    last_acc = 1'b0;
    while ((sent < N || exp_q.size() != 0) && budget < 60000) begin
      if (!in_valid || last_acc) begin
        if (sent < N && $urandom_range(3) != 0) begin
          logic [W-1:0] a;
          int           sh;
          logic [1:0]   op;
          a  = $urandom();
          sh = $urandom_range(W - 1);
          op = 2'($urandom_range(3));
          present(a, sh, op, ref_shift(a, sh, op));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      step();
      if (last_acc) sent++;
      budget++;
    end
    n_checks++;
    if (sent != N || exp_q.size() != 0)
      $display("FAIL random_end: got sent=%0d outstanding=%0d expected %0d and 0", sent, exp_q.size(), N);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_extremes();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
